// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  localparam int CNT_W = 8;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant picker: a lone request always wins; on contention the port
// other than last_owner_i is served.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_owner_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic m1_turn;

  assign m1_turn = (last_owner_i == OWN_M0);
  assign gnt0_o  = req0_i & (~req1_i | ~m1_turn);
  assign gnt1_o  = req1_i & (~req0_i | m1_turn);

endmodule

// File: rtl/mem_arbiter.sv
// Data/fetch port arbiter onto one slave, one transaction in flight.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin; default is m0 priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  input  logic              m1_req_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic              s_ack_i,
  input  logic [DATA_W-1:0] s_rdata_i,
  output logic              hold_flag_o
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sreq_q, sreq_d;
  logic              rv0_q, rv0_d;
  logic              rv1_q, rv1_d;
  logic              err_q, err_d;
  logic              last_owner;
  logic              pick0, pick1;
  logic              gnt0, gnt1;
  logic              done;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  assign last_owner = last_q;
  assign last_d = gnt1 ? OWN_M1 :
                  gnt0 ? OWN_M0 : last_q;

  // Reset to m1 so the first contention favours m0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= OWN_M1;
    else        last_q <= last_d;
  end
`else
  assign last_owner = OWN_M1;
`endif

  mem_arb_pick u_pick (
    .req0_i       (m0_req_i),
    .req1_i       (m1_req_i),
    .last_owner_i (last_owner),
    .gnt0_o       (pick0),
    .gnt1_o       (pick1)
  );

  assign gnt0 = (state_q == ST_IDLE) & pick0;
  assign gnt1 = (state_q == ST_IDLE) & pick1;
  assign done = s_ack_i | (cnt_q == CNT_W'(WAIT_MAX));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    sreq_d  = sreq_q;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt0 | gnt1) begin
          state_d = ST_BUSY;
          owner_d = gnt1 ? OWN_M1 : OWN_M0;
          we_d    = gnt0 & m0_we_i;
          addr_d  = gnt1 ? m1_addr_i : m0_addr_i;
          wdata_d = gnt1 ? '0 : m0_wdata_i;
          cnt_d   = '0;
          sreq_d  = 1'b1;
        end
      end
      ST_BUSY: begin
        if (done) begin
          state_d = ST_IDLE;
          sreq_d  = 1'b0;
          rv0_d   = (owner_q == OWN_M0);
          rv1_d   = (owner_q == OWN_M1);
          // A late ack on the timeout cycle still counts as success.
          err_d   = ~s_ack_i;
          rdata_d = (s_ack_i & ~we_q) ? s_rdata_i : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_M0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      sreq_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      sreq_q  <= sreq_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      err_q   <= err_d;
    end
  end

  assign m0_gnt_o    = gnt0;
  assign m1_gnt_o    = gnt1;
  assign m0_rvalid_o = rv0_q;
  assign m1_rvalid_o = rv1_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign s_req_o     = sreq_q;
  assign s_we_o      = we_q;
  assign s_addr_o    = addr_q;
  assign s_wdata_o   = wdata_q;
  assign hold_flag_o = m1_req_i & ~gnt1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model.
// Honours MEM_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WM = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req_i, m0_we_i, m1_req_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [DW-1:0] m0_wdata_i, s_rdata_i;
  logic          s_ack_i;
  logic          m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [DW-1:0] rdata_o, s_wdata_o;
  logic          err_o, s_req_o, s_we_o, hold_flag_o;
  logic [AW-1:0] s_addr_o;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_MAX(WM)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_req_i    (m0_req_i),
    .m0_we_i     (m0_we_i),
    .m0_addr_i   (m0_addr_i),
    .m0_wdata_i  (m0_wdata_i),
    .m0_gnt_o    (m0_gnt_o),
    .m0_rvalid_o (m0_rvalid_o),
    .m1_req_i    (m1_req_i),
    .m1_addr_i   (m1_addr_i),
    .m1_gnt_o    (m1_gnt_o),
    .m1_rvalid_o (m1_rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .s_req_o     (s_req_o),
    .s_we_o      (s_we_o),
    .s_addr_o    (s_addr_o),
    .s_wdata_o   (s_wdata_o),
    .s_ack_i     (s_ack_i),
    .s_rdata_i   (s_rdata_i),
    .hold_flag_o (hold_flag_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: one transaction record plus the pulse seen this cycle.
  int            cyc = 0;
  int            m_deadline;
  bit            m_busy, m_owner, m_we, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, d_rdata;
  bit            d_rv0, d_rv1, d_err;

  function automatic logic [1:0] exp_gnt(input logic r0, input logic r1);
    bit rr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    if (r0 && r1) return (rr && m_last == 1'b0) ? 2'b10 : 2'b01;
    return {r1, r0};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [1:0] g;
    if (!rst_n) begin
      m_busy = 0; m_owner = 0; m_we = 0; m_last = 1;
      m_addr = '0; m_wdata = '0; m_deadline = 0;
      d_rv0 = 0; d_rv1 = 0; d_err = 0; d_rdata = '0;
    end else begin
      d_rv0 = 0; d_rv1 = 0; d_err = 0; d_rdata = '0;
      if (m_busy) begin
        if (s_ack_i || cyc == m_deadline) begin
          m_busy  = 0;
          d_rv0   = !m_owner;
          d_rv1   = m_owner;
          d_err   = !s_ack_i;
          d_rdata = (s_ack_i && !m_we) ? s_rdata_i : '0;
        end
      end else begin
        g = exp_gnt(m0_req_i, m1_req_i);
        if (g != 2'b00) begin
          m_busy     = 1;
          m_owner    = g[1];
          m_we       = g[0] & m0_we_i;
          m_addr     = g[1] ? m1_addr_i : m0_addr_i;
          m_wdata    = m0_wdata_i;
          m_last     = g[1];
          m_deadline = cyc + 1 + WM;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    logic [1:0] g;
    g = m_busy ? 2'b00 : exp_gnt(m0_req_i, m1_req_i);
    chk("m0_gnt", m0_gnt_o, g[0]);
    chk("m1_gnt", m1_gnt_o, g[1]);
    chk("hold", hold_flag_o, m1_req_i & ~g[1]);
    chk("s_req", s_req_o, m_busy);
    chk("m0_rvalid", m0_rvalid_o, d_rv0);
    chk("m1_rvalid", m1_rvalid_o, d_rv1);
    if (m_busy) begin
      chk("s_we", s_we_o, m_we);
      chk("s_addr", s_addr_o, m_addr);
      if (m_we) chk("s_wdata", s_wdata_o, m_wdata);
    end
    if (d_rv0 || d_rv1) begin
      chk("err", err_o, d_err);
      chk("rdata", rdata_o, d_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int seq [4];
  int exp_seq [4];
  int n;

  initial begin
    rst_n = 0; s_ack_i = 0; s_rdata_i = '0;
    m0_req_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_wdata_i = '0;
    m1_req_i = 0; m1_addr_i = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    repeat (3) tick();
    @(negedge clk);
    chk("rst_sreq", s_req_o, 0);
    chk("rst_addr", s_addr_o, 0);
    chk("rst_outs", {m0_rvalid_o, m1_rvalid_o, err_o, s_we_o}, 0);
    tick(); rst_n = 1;

    // m1 read, ack two cycles after s_req_o rises
    tick(); m1_req_i = 1; m1_addr_i = 'h100;
    @(negedge clk); chk("t1_gnt", m1_gnt_o, 1);
    tick(); m1_req_i = 0;
    tick();
    tick(); s_ack_i = 1; s_rdata_i = 'hDEADBEEF;
    tick(); s_ack_i = 0; s_rdata_i = '0;
    @(negedge clk);
    chk("t1_rv", m1_rvalid_o, 1);
    chk("t1_rdata", rdata_o, 'hDEADBEEF);
    chk("t1_err", err_o, 0);

    // m0 write; request dropped right after grant
    tick(); m0_req_i = 1; m0_we_i = 1;
    m0_addr_i = 'h200; m0_wdata_i = 'h12345678;
    tick(); m0_req_i = 0; m0_we_i = 0;
    m0_addr_i = '0; m0_wdata_i = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t2_we", s_we_o, 1);
      chk("t2_addr", s_addr_o, 'h200);
      chk("t2_wdata", s_wdata_o, 'h12345678);
      tick();
    end
    s_ack_i = 1; s_rdata_i = 'hFFFF;
    tick(); s_ack_i = 0; s_rdata_i = '0;
    @(negedge clk);
    chk("t2_rv", m0_rvalid_o, 1);
    chk("t2_rdata", rdata_o, 0);

    // contention, fresh pointer
    tick(); rst_n = 0;
    tick(); rst_n = 1;
    tick(); m0_req_i = 1; m1_req_i = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seq[i] = m1_gnt_o ? 1 : (m0_gnt_o ? 0 : 3);
`ifndef MEM_ARB_ROUND_ROBIN_EN
      chk("t3_hold", hold_flag_o, 1);
`endif
      tick(); s_ack_i = 1;
      if (i == 3) begin m0_req_i = 0; m1_req_i = 0; end
      tick(); s_ack_i = 0;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("t3_seq%0d", i), seq[i], exp_seq[i]);

    // timeout, with m1 waiting to be served straight after
    tick(); m0_req_i = 1; m0_addr_i = 'h300;
    tick(); m0_req_i = 0; m1_req_i = 1; m1_addr_i = 'h400;
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (m0_rvalid_o) break;
      tick();
      n++;
    end
    chk("t4_latency", n, WM + 2);
    chk("t4_err", err_o, 1);
    chk("t4_rdata", rdata_o, 0);
    chk("t4_sreq", s_req_o, 0);
    chk("t4_next_gnt", m1_gnt_o, 1);

    // ack on the timeout cycle wins
    tick(); m1_req_i = 0;
    repeat (WM) tick();
    s_ack_i = 1; s_rdata_i = 'hA5A5;
    tick(); s_ack_i = 0; s_rdata_i = '0;
    @(negedge clk);
    chk("t4b_rv", m1_rvalid_o, 1);
    chk("t4b_err", err_o, 0);
    chk("t4b_rdata", rdata_o, 'hA5A5);

    // stray ack while idle
    tick(); s_ack_i = 1;
    tick(); s_ack_i = 0;
    @(negedge clk);
    chk("t5_norv", {m0_rvalid_o, m1_rvalid_o}, 0);

    // reset in the middle of a write
    tick(); m0_req_i = 1; m0_we_i = 1;
    m0_addr_i = 'h500; m0_wdata_i = 'h7;
    tick(); m0_req_i = 0; m0_we_i = 0;
    tick(); #1 rst_n = 0;
    @(negedge clk);
    chk("t6_sreq", s_req_o, 0);
    chk("t6_fields", {s_we_o, s_addr_o, s_wdata_o}, 0);
    chk("t6_rv", {m0_rvalid_o, m1_rvalid_o, err_o}, 0);
    tick();
    tick(); rst_n = 1; m1_req_i = 1; m1_addr_i = 'h600;
    @(negedge clk);
    chk("t6_gnt", m1_gnt_o, 1);
    chk("t6_norv", {m0_rvalid_o, m1_rvalid_o}, 0);
    tick(); m1_req_i = 0;
    tick(); s_ack_i = 1; s_rdata_i = 'h55;
    tick(); s_ack_i = 0; s_rdata_i = '0;
    tick();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter WAIT_MAX, default 15, slave-ack timeout in cycles (1..255).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 m0_req_i  input  1  data-port (load/store) request.
REQ-007 m0_we_i  input  1  data-port write enable.
REQ-008 m0_addr_i  input  ADDR_W  data-port address.
REQ-009 m0_wdata_i  input  DATA_W  data-port write data.
REQ-010 m0_gnt_o  output  1  data-port grant pulse.
REQ-011 m0_rvalid_o  output  1  data-port completion pulse.
REQ-012 m1_req_i  input  1  fetch-port read request.
REQ-013 m1_addr_i  input  ADDR_W  fetch address.
REQ-014 m1_gnt_o  output  1  fetch grant pulse.
REQ-015 m1_rvalid_o  output  1  fetch completion pulse.
REQ-016 rdata_o  output  DATA_W  read data, valid with either rvalid.
REQ-017 err_o  output  1  timeout error, valid with either rvalid.
REQ-018 s_req_o  output  1  slave request, held until ack.
REQ-019 s_we_o  output  1  slave write enable.
REQ-020 s_addr_o  output  ADDR_W  slave address.
REQ-021 s_wdata_o  output  DATA_W  slave write data.
REQ-022 s_ack_i  input  1  slave ack; s_rdata_i valid same cycle.
REQ-023 s_rdata_i  input  DATA_W  slave read data.
REQ-024 hold_flag_o  output  1  pipeline hold to ctrl: m1_req_i high and m1_gnt_o low.

Function
REQ-025 FSM states IDLE, BUSY; exactly one transaction outstanding.
REQ-026 In IDLE, gnt outputs are combinational from requests; at most one gnt high per cycle; no gnt in BUSY.
REQ-027 On grant at cycle N: latch owner, we (0 for m1), addr, wdata; enter BUSY; s_req_o/s_we_o/s_addr_o/s_wdata_o registered, high/valid from N+1.
REQ-028 In BUSY, s_req_o and latched fields stay stable until s_ack_i.
REQ-029 s_ack_i at cycle K: owner rvalid pulses at K+1 for one cycle; rdata_o = registered s_rdata_i (0 for writes); err_o=0; s_req_o low at K+1; state IDLE at K+1, new grant allowed at K+1.
REQ-030 Wait counter starts at 0 on entry to BUSY, increments each BUSY cycle without ack; at count WAIT_MAX without ack: drop s_req_o, pulse owner rvalid with err_o=1, rdata_o=0, return to IDLE.
REQ-031 s_ack_i and s_ack_i in the same cycle as timeout: ack wins (err_o=0).
REQ-032 s_ack_i while IDLE is ignored.
REQ-033 Requester deasserting req after grant does not cancel the transaction.
REQ-034 Both requests in IDLE: selection per Configuration; loser gets no gnt and retries next IDLE cycle.

Reset
REQ-035 rst_n low, at any time incl. mid-BUSY: state IDLE, all outputs 0, counter 0, latched fields 0, round-robin pointer to m0-preferred; aborted transaction produces no rvalid.

Configuration
REQ-036 Macro MEM_ARB_ROUND_ROBIN_EN defined: on contention grant the port not served last (1-bit last-owner register, updated on each grant).
REQ-037 Macro undefined: fixed priority, m0 always wins contention; no last-owner register.

Structure
REQ-038 Shared package mem_arb_pkg holds FSM state encoding, owner IDs (OWN_M0, OWN_M1), counter width constant.
REQ-039 Grant selection in sub-module mem_arb_pick (combinational: req0, req1, last_owner -> gnt0, gnt1).

Verification
REQ-040 m1 read 0x100, slave acks 2 cycles after s_req_o, s_rdata_i=0xDEADBEEF -> m1_rvalid_o one cycle after ack, rdata_o=0xDEADBEEF, err_o=0.
REQ-041 m0 write 0x200 data 0x12345678 -> s_we_o=1, s_addr_o=0x200 stable until ack; m0_rvalid_o with rdata_o=0.
REQ-042 m0 and m1 request together for 4 transactions -> fixed: m0,m0,m0,m0 while m0 holds req, hold_flag_o high throughout; round-robin: m0,m1,m0,m1.
REQ-043 No ack for WAIT_MAX=15 cycles -> err_o=1 with owner rvalid, s_req_o low, next request granted next cycle.
REQ-044 rst_n low mid-BUSY then released -> no rvalid, all outputs 0, fresh m1 request granted in first IDLE cycle.
